// File: rtl/spi_queue_pkg.sv
// Shared definitions for the multi-channel SPI queue block.
//   chan_w()      : width of the channel select (at least 1 bit)
//   cnt_w()       : width of a FIFO occupancy count able to hold 0..n
//   fifo_status_t : per-FIFO status (occupancy, full, empty)
package spi_queue_pkg;

  // Widest occupancy the status struct can carry.
  localparam int CNT_MAX_W = 16;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // The count field is zero-extended from the FIFO's natural count width.
  typedef struct packed {
    logic [CNT_MAX_W-1:0] count;
    logic                 full;
    logic                 empty;
  } fifo_status_t;

endpackage

// File: rtl/spi_chan_fifo.sv
// Single-clock FIFO of NUM_ENTRIES messages (any depth >= 2).
// Registered regfile with a combinational read at the read pointer, so an
// entry written at edge N is visible on deq_msg after edge N; no bypass.
//
// Handshake: enqueue fires when enq_val is high and the FIFO is not full
// (enq_rdy == !status.full); dequeue fires when deq_rdy is high and the
// FIFO is not empty (deq_val == !status.empty). A full FIFO refuses an
// enqueue even if a dequeue fires in the same cycle.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears storage too)
//   flush       : empty the FIFO at the next edge; beats any enq/deq
//   enq_val     : enqueue request, enq_msg is the data
//   deq_rdy     : dequeue request, deq_msg is the head entry
//   status      : occupancy, full (= !enq_rdy), empty (= !deq_val)
module spi_chan_fifo
  import spi_queue_pkg::*;
#(
  parameter int PACK_SIZE   = 32,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 enq_val,
  input  logic [PACK_SIZE-1:0] enq_msg,
  input  logic                 deq_rdy,
  output logic [PACK_SIZE-1:0] deq_msg,
  output fifo_status_t         status
);

  localparam int CNTW = cnt_w(NUM_ENTRIES);
  localparam int AW   = $clog2(NUM_ENTRIES);
  localparam logic [AW-1:0]   LAST_PTR = AW'(NUM_ENTRIES - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NUM_ENTRIES);

  logic [PACK_SIZE-1:0] mem [NUM_ENTRIES];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 enq_rdy;
  logic                 deq_val;
  logic                 enq_fire;
  logic                 deq_fire;

  assign enq_rdy  = (count < FULL_CNT);
  assign deq_val  = (count != '0);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_rdy & deq_val;
  assign deq_msg  = mem[rd_ptr];

  always_comb begin
    status.count = CNT_MAX_W'(count);
    status.full  = !enq_rdy;
    status.empty = !deq_val;
  end

  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        mem[wr_ptr] <= enq_msg;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      // enq needs count < N and deq needs count > 0, so no saturation logic
      if (enq_fire && !deq_fire) begin
        count <= count + 1'b1;
      end else if (!enq_fire && deq_fire) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_queue_mc.sv
// Multi-channel SPI message queue. Each of NUM_CHANNELS channels has a TX
// FIFO (master -> device) and an RX FIFO (device -> master). The master side
// is shared and steered by chan_sel; each device side has its own val/rdy
// pair and runs concurrently with every other channel.
//
// Handshake: a transfer happens on a cycle where both val and rdy are high.
// Master enqueue val is serve & !hard_msg, master dequeue rdy is seize.
// Device side: send_val/send_rdy drain TX, recv_val/recv_rdy fill RX.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   chan_sel          : master-side channel; values >= NUM_CHANNELS read as
//                       zero and make serve/seize/flush/err_clear no-ops
//   serve, hard_msg   : enqueue from_master into TX[chan_sel] unless hard_msg
//   seize             : dequeue RX[chan_sel]; to_master/to_master_val = head
//   flush             : empty both FIFOs of chan_sel (errors untouched)
//   err_clear         : clear sticky errors of chan_sel (a new error wins)
//   send_*            : per-channel TX head, packed PACK_SIZE per channel
//   recv_*            : per-channel RX input, same packing
//   tx_count/rx_count : occupancy of the selected channel's FIFOs
//   tx_almost_full    : tx_count >= AF_THRESH
//   rx_almost_empty   : rx_count <= AE_THRESH
//   err_overflow      : sticky, serve dropped because TX was full
//   err_underflow     : sticky, seize while RX was empty
module spi_queue_mc
  import spi_queue_pkg::*;
#(
  parameter int PACK_SIZE    = 32,
  parameter int NUM_ENTRIES  = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int AF_THRESH    = NUM_ENTRIES - 1,
  parameter int AE_THRESH    = 1,
  localparam int CW   = chan_w(NUM_CHANNELS),
  localparam int CNTW = cnt_w(NUM_ENTRIES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CW-1:0]                     chan_sel,
  input  logic                              serve,
  input  logic                              hard_msg,
  input  logic [PACK_SIZE-1:0]              from_master,
  input  logic                              seize,
  output logic [PACK_SIZE-1:0]              to_master,
  output logic                              to_master_val,
  input  logic                              flush,
  input  logic                              err_clear,
  output logic [NUM_CHANNELS-1:0]           send_val,
  input  logic [NUM_CHANNELS-1:0]           send_rdy,
  output logic [NUM_CHANNELS*PACK_SIZE-1:0] send_msg,
  input  logic [NUM_CHANNELS-1:0]           recv_val,
  output logic [NUM_CHANNELS-1:0]           recv_rdy,
  input  logic [NUM_CHANNELS*PACK_SIZE-1:0] recv_msg,
  output logic [CNTW-1:0]                   tx_count,
  output logic [CNTW-1:0]                   rx_count,
  output logic                              tx_almost_full,
  output logic                              rx_almost_empty,
  output logic [NUM_CHANNELS-1:0]           err_overflow,
  output logic [NUM_CHANNELS-1:0]           err_underflow
);

  logic                    enq_req;
  logic [NUM_CHANNELS-1:0] sel_hit;
  logic [NUM_CHANNELS-1:0] ov_set;
  logic [NUM_CHANNELS-1:0] un_set;
  logic [NUM_CHANNELS-1:0] clr;
  fifo_status_t            tx_st   [NUM_CHANNELS];
  fifo_status_t            rx_st   [NUM_CHANNELS];
  logic [PACK_SIZE-1:0]    rx_head [NUM_CHANNELS];
  logic [CNT_MAX_W-1:0]    sel_tx_cnt;
  logic [CNT_MAX_W-1:0]    sel_rx_cnt;

  assign enq_req = serve & ~hard_msg;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    // An out-of-range chan_sel matches no channel, so every master-side
    // action is dropped and every master-side read falls to zero.
    assign sel_hit[c] = (chan_sel == CW'(c));

    spi_chan_fifo #(
      .PACK_SIZE   (PACK_SIZE),
      .NUM_ENTRIES (NUM_ENTRIES)
    ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush & sel_hit[c]),
      .enq_val (enq_req & sel_hit[c]),
      .enq_msg (from_master),
      .deq_rdy (send_rdy[c]),
      .deq_msg (send_msg[c*PACK_SIZE +: PACK_SIZE]),
      .status  (tx_st[c])
    );

    spi_chan_fifo #(
      .PACK_SIZE   (PACK_SIZE),
      .NUM_ENTRIES (NUM_ENTRIES)
    ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush & sel_hit[c]),
      .enq_val (recv_val[c]),
      .enq_msg (recv_msg[c*PACK_SIZE +: PACK_SIZE]),
      .deq_rdy (seize & sel_hit[c]),
      .deq_msg (rx_head[c]),
      .status  (rx_st[c])
    );

    assign send_val[c] = ~tx_st[c].empty;
    assign recv_rdy[c] = ~rx_st[c].full;
    assign ov_set[c]   = enq_req & sel_hit[c] & tx_st[c].full;
    assign un_set[c]   = seize & sel_hit[c] & rx_st[c].empty;
    assign clr[c]      = err_clear & sel_hit[c];
  end

  // Master-side readback mux.
  always_comb begin
    to_master     = '0;
    to_master_val = 1'b0;
    sel_tx_cnt    = '0;
    sel_rx_cnt    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel_hit[c]) begin
        to_master     = rx_head[c];
        to_master_val = ~rx_st[c].empty;
        sel_tx_cnt    = tx_st[c].count;
        sel_rx_cnt    = rx_st[c].count;
      end
    end
  end

  assign tx_count        = sel_tx_cnt[CNTW-1:0];
  assign rx_count        = sel_rx_cnt[CNTW-1:0];
  assign tx_almost_full  = (int'(sel_tx_cnt) >= AF_THRESH);
  assign rx_almost_empty = (int'(sel_rx_cnt) <= AE_THRESH);

  // Sticky error flags: a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ov_set[c])   err_overflow[c] <= 1'b1;
        else if (clr[c]) err_overflow[c] <= 1'b0;
        if (un_set[c])   err_underflow[c] <= 1'b1;
        else if (clr[c]) err_underflow[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_queue_mc.sv
// Bench for spi_queue_mc. Two instances share the stimulus:
//   dut_a : defaults (4 entries, 2 channels)
//   dut_b : 3 entries, 3 channels (non-power-of-2 depth, out-of-range chan_sel)
// A queue-based model per FIFO predicts every output each cycle.
module tb_spi_queue_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cs_a;
  logic [1:0]  cs_b;
  logic        serve, hard_msg, seize, flush, err_clear;
  logic [31:0] from_master;
  logic [2:0]  send_rdy, recv_val;
  logic [95:0] recv_msg;

  logic [31:0] a_tm;   logic a_tmv;  logic [1:0] a_sval; logic [63:0] a_smsg;
  logic [1:0]  a_rrdy; logic [2:0] a_txc, a_rxc; logic a_af, a_ae;
  logic [1:0]  a_ov, a_un;
  logic [31:0] b_tm;   logic b_tmv;  logic [2:0] b_sval; logic [95:0] b_smsg;
  logic [2:0]  b_rrdy; logic [1:0] b_txc, b_rxc; logic b_af, b_ae;
  logic [2:0]  b_ov, b_un;

  spi_queue_mc #(.PACK_SIZE(32), .NUM_ENTRIES(4), .NUM_CHANNELS(2)) dut_a (
    .clk(clk), .reset(reset), .chan_sel(cs_a), .serve(serve), .hard_msg(hard_msg),
    .from_master(from_master), .seize(seize), .to_master(a_tm), .to_master_val(a_tmv),
    .flush(flush), .err_clear(err_clear), .send_val(a_sval), .send_rdy(send_rdy[1:0]),
    .send_msg(a_smsg), .recv_val(recv_val[1:0]), .recv_rdy(a_rrdy),
    .recv_msg(recv_msg[63:0]), .tx_count(a_txc), .rx_count(a_rxc),
    .tx_almost_full(a_af), .rx_almost_empty(a_ae),
    .err_overflow(a_ov), .err_underflow(a_un)
  );

  spi_queue_mc #(.PACK_SIZE(32), .NUM_ENTRIES(3), .NUM_CHANNELS(3)) dut_b (
    .clk(clk), .reset(reset), .chan_sel(cs_b), .serve(serve), .hard_msg(hard_msg),
    .from_master(from_master), .seize(seize), .to_master(b_tm), .to_master_val(b_tmv),
    .flush(flush), .err_clear(err_clear), .send_val(b_sval), .send_rdy(send_rdy),
    .send_msg(b_smsg), .recv_val(recv_val), .recv_rdy(b_rrdy),
    .recv_msg(recv_msg), .tx_count(b_txc), .rx_count(b_rxc),
    .tx_almost_full(b_af), .rx_almost_empty(b_ae),
    .err_overflow(b_ov), .err_underflow(b_un)
  );

  // ---------------- reference model ----------------
  // mq[k*6 + c*2 + d]: instance k, channel c, d=0 TX / d=1 RX, front = head.
  logic [31:0] mq [12][$];
  bit          ov_m [2][3];
  bit          un_m [2][3];
  bit          model_ok = 1'b0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  function automatic int qi(int k, int c, int d);
    return k * 6 + c * 2 + d;
  endfunction
  function automatic int depth(int k);
    return (k == 0) ? 4 : 3;
  endfunction
  function automatic int nch(int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic bit coin(int num, int den);
    return $urandom_range(0, den - 1) < num;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int k);
    logic [2:0]  sval, rrdy, ov, un, txc, rxc;
    logic [95:0] smsg;
    logic [31:0] tm;
    logic        tmv, af, ae;
    int cs, nc, d, etx, erx;
    bit valid;
    nc = nch(k);
    d  = depth(k);
    if (k == 0) begin
      sval = {1'b0, a_sval}; rrdy = {1'b0, a_rrdy}; ov = {1'b0, a_ov}; un = {1'b0, a_un};
      smsg = {32'h0, a_smsg}; txc = a_txc; rxc = a_rxc; tm = a_tm; tmv = a_tmv;
      af = a_af; ae = a_ae; cs = int'(cs_a);
    end else begin
      sval = b_sval; rrdy = b_rrdy; ov = b_ov; un = b_un; smsg = b_smsg;
      txc = {1'b0, b_txc}; rxc = {1'b0, b_rxc}; tm = b_tm; tmv = b_tmv;
      af = b_af; ae = b_ae; cs = int'(cs_b);
    end
    for (int c = 0; c < nc; c++) begin
      chk($sformatf("i%0d send_val[%0d]", k, c), sval[c], mq[qi(k, c, 0)].size() != 0);
      if (mq[qi(k, c, 0)].size() != 0)
        chk($sformatf("i%0d send_msg[%0d]", k, c), smsg[c*32 +: 32], mq[qi(k, c, 0)][0]);
      chk($sformatf("i%0d recv_rdy[%0d]", k, c), rrdy[c], mq[qi(k, c, 1)].size() < d);
      chk($sformatf("i%0d err_overflow[%0d]", k, c), ov[c], ov_m[k][c]);
      chk($sformatf("i%0d err_underflow[%0d]", k, c), un[c], un_m[k][c]);
    end
    valid = (cs < nc);
    etx = valid ? mq[qi(k, cs, 0)].size() : 0;
    erx = valid ? mq[qi(k, cs, 1)].size() : 0;
    chk($sformatf("i%0d tx_count", k), txc, etx);
    chk($sformatf("i%0d rx_count", k), rxc, erx);
    chk($sformatf("i%0d tx_almost_full", k), af, etx >= d - 1);
    chk($sformatf("i%0d rx_almost_empty", k), ae, erx <= 1);
    chk($sformatf("i%0d to_master_val", k), tmv, erx != 0);
    if (erx != 0) chk($sformatf("i%0d to_master", k), tm, mq[qi(k, cs, 1)][0]);
    else if (!valid) chk($sformatf("i%0d to_master oob", k), tm, 0);
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_update();
    int cs, nc, d, ti, ri, tsz, rsz;
    bit hit, t_enq, t_deq, r_enq, r_deq, ov_set, un_set;
    if (reset) begin
      for (int i = 0; i < 12; i++) mq[i].delete();
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 3; c++) begin
          ov_m[k][c] = 1'b0;
          un_m[k][c] = 1'b0;
        end
      model_ok = 1'b1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      nc = nch(k);
      d  = depth(k);
      cs = (k == 0) ? int'(cs_a) : int'(cs_b);
      for (int c = 0; c < nc; c++) begin
        hit = (cs == c);
        ti = qi(k, c, 0);
        ri = qi(k, c, 1);
        tsz = mq[ti].size();
        rsz = mq[ri].size();
        t_enq  = serve && !hard_msg && hit && tsz < d;
        t_deq  = send_rdy[c] && tsz > 0;
        r_enq  = recv_val[c] && rsz < d;
        r_deq  = seize && hit && rsz > 0;
        ov_set = serve && !hard_msg && hit && tsz == d;
        un_set = seize && hit && rsz == 0;
        if (ov_set) ov_m[k][c] = 1'b1;
        else if (err_clear && hit) ov_m[k][c] = 1'b0;
        if (un_set) un_m[k][c] = 1'b1;
        else if (err_clear && hit) un_m[k][c] = 1'b0;
        if (flush && hit) begin
          mq[ti].delete();
          mq[ri].delete();
        end else begin
          if (t_deq) void'(mq[ti].pop_front());
          if (t_enq) mq[ti].push_back(from_master);
          if (r_deq) void'(mq[ri].pop_front());
          if (r_enq) mq[ri].push_back(recv_msg[c*32 +: 32]);
        end
      end
    end
  endtask

  // Inputs are set after posedge+1; outputs are compared on the negedge,
  // then the model steps across the next posedge.
  task automatic step();
    @(negedge clk);
    if (model_ok) begin
      check_inst(0);
      check_inst(1);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    serve = 0; hard_msg = 0; seize = 0; flush = 0; err_clear = 0;
    from_master = '0; send_rdy = '0; recv_val = '0; recv_msg = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sav_ov, sav_un;
    reset = 1; cs_a = 0; cs_b = 0;
    idle();
    step();
    step();
    reset = 0;
    // reset values
    chk("rst send_val", a_sval, 2'b00);
    chk("rst recv_rdy", a_rrdy, 2'b11);
    chk("rst to_master_val", a_tmv, 0);
    chk("rst to_master", a_tm, 0);
    chk("rst send_msg", a_smsg, 0);
    chk("rst tx_count", a_txc, 0);
    chk("rst rx_count", a_rxc, 0);
    chk("rst tx_almost_full", a_af, 0);
    chk("rst rx_almost_empty", a_ae, 1);
    chk("rst err", {a_ov, a_un}, 0);
    chk("rst b recv_rdy", b_rrdy, 3'b111);

    // fill ch0 TX, then overflow with a fifth serve
    for (int i = 0; i < 5; i++) begin
      serve = 1; from_master = 32'hA + i;
      step();
      if (i < 4) chk($sformatf("fill%0d tx_almost_full", i), a_af, i >= 2);
    end
    serve = 0;
    chk("full tx_count", a_txc, 4);
    chk("full err_overflow", a_ov, 2'b01);
    chk("full send_val0", a_sval[0], 1);
    chk("full send_msg0", a_smsg[31:0], 32'hA);

    // drain ch0 TX in order
    send_rdy = 3'b001;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d send_msg0", i), a_smsg[31:0], 32'hA + i);
      step();
    end
    send_rdy = 0;
    chk("drained send_val0", a_sval[0], 0);

    // underflow on ch0, then clear
    seize = 1;
    chk("pre underflow", a_un[0], 0);
    step();
    seize = 0;
    chk("underflow set", a_un[0], 1);
    err_clear = 1;
    step();
    err_clear = 0;
    chk("underflow clr", a_un[0], 0);

    // simultaneous recv and seize on ch1 with two entries held
    cs_a = 1; cs_b = 1;
    recv_val = 3'b010;
    recv_msg[63:32] = 32'h11; step();
    recv_msg[63:32] = 32'h22; step();
    chk("ch1 rx_count 2", a_rxc, 2);
    chk("ch1 head 11", a_tm, 32'h11);
    recv_msg[63:32] = 32'h33; seize = 1;
    step();
    seize = 0; recv_val = 0;
    chk("ch1 simul rx_count", a_rxc, 2);
    chk("ch1 simul head", a_tm, 32'h22);

    // fill ch1 TX, one entry in ch0 RX, then flush ch1 with a serve
    serve = 1; from_master = 32'h51; recv_val = 3'b001; recv_msg[31:0] = 32'h61;
    step();
    from_master = 32'h52; recv_val = 0;
    step();
    chk("pre flush tx_count", a_txc, 2);
    sav_ov = a_ov; sav_un = a_un;
    flush = 1; from_master = 32'h77;
    step();
    flush = 0; serve = 0;
    chk("flush tx_count", a_txc, 0);
    chk("flush rx_count", a_rxc, 0);
    chk("flush err_overflow", a_ov, sav_ov);
    chk("flush err_underflow", a_un, sav_un);
    cs_a = 0; cs_b = 0;
    #1;
    chk("flush ch0 rx_count", a_rxc, 1);

    // alternating enqueue/dequeue on ch0 so the 3-deep pointers wrap
    for (int i = 0; i < 2; i++) begin
      serve = 1; from_master = 32'h100 + i; step();
    end
    for (int i = 0; i < 10; i++) begin
      serve = (i % 2 == 0); send_rdy = (i % 2 == 0) ? 3'b000 : 3'b001;
      from_master = 32'h200 + i;
      step();
      chk($sformatf("wrap%0d b tx_count<=3", i), b_txc <= 2'd3 && b_txc != 0, 1);
    end
    idle();

    // randomized traffic, alternating fill-biased and drain-biased windows
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit fill;
      fill = ((cyc / 150) % 2) == 0;
      reset     = ($urandom_range(0, 299) == 0);
      cs_a      = 1'($urandom_range(0, 1));
      cs_b      = 2'($urandom_range(0, 3));
      serve     = coin(1, 2);
      hard_msg  = coin(1, 8);
      from_master = $urandom;
      seize     = fill ? coin(1, 6) : coin(1, 2);
      flush     = coin(1, 40);
      err_clear = coin(1, 20);
      for (int c = 0; c < 3; c++) begin
        send_rdy[c] = fill ? coin(1, 5) : coin(3, 4);
        recv_val[c] = fill ? coin(1, 2) : coin(1, 5);
      end
      recv_msg = {$urandom, $urandom, $urandom};
      step();
    end
    reset = 0;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_queue_mc.md
Name: spi_queue_mc

Overview:
- Multi-channel successor to the single-channel SPI master/device queue pair.
- Provides NUM_CHANNELS independent channel pairs. Each pair has one TX FIFO (master to device) and one RX FIFO (device to master).
- The master side is shared and steered by chan_sel. The device side is one val/rdy pair per channel.
- Adds arbitrary (non-power-of-2) depth, per-channel flush, almost-full/almost-empty flags, occupancy readback and sticky overflow/underflow error flags.
- Sits between the SPI master-side register/control logic and the per-device SPI minion adapters.

Parameters:
- PACK_SIZE, 32, message width in bits; multiple of 4.
- NUM_ENTRIES, 4, entries per FIFO; any value >= 2 (power of 2 not required).
- NUM_CHANNELS, 2, number of channel pairs; >= 1.
- AF_THRESH, NUM_ENTRIES-1, TX almost-full asserts when count >= AF_THRESH.
- AE_THRESH, 1, RX almost-empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chan_sel  in  CW  master-side channel select; CW = max(1, clog2(NUM_CHANNELS))
- serve  in  1  master enqueue request to TX FIFO[chan_sel]
- hard_msg  in  1  suppresses serve (no enqueue) when high
- from_master  in  PACK_SIZE  enqueue data
- seize  in  1  master dequeue request from RX FIFO[chan_sel]
- to_master  out  PACK_SIZE  head of RX FIFO[chan_sel] (combinational)
- to_master_val  out  1  RX FIFO[chan_sel] non-empty
- flush  in  1  empty both FIFOs of channel chan_sel
- err_clear  in  1  clear sticky error flags of channel chan_sel
- send_val  out  NUM_CHANNELS  per-channel TX head valid
- send_rdy  in  NUM_CHANNELS  per-channel device ready
- send_msg  out  NUM_CHANNELS*PACK_SIZE  per-channel TX head; channel i at [i*PACK_SIZE +: PACK_SIZE]
- recv_val  in  NUM_CHANNELS  per-channel device data valid
- recv_rdy  out  NUM_CHANNELS  per-channel RX not full
- recv_msg  in  NUM_CHANNELS*PACK_SIZE  per-channel RX data, same packing as send_msg
- tx_count  out  clog2(NUM_ENTRIES+1)  occupancy of TX FIFO[chan_sel]
- rx_count  out  clog2(NUM_ENTRIES+1)  occupancy of RX FIFO[chan_sel]
- tx_almost_full  out  1  TX FIFO[chan_sel] count >= AF_THRESH
- rx_almost_empty  out  1  RX FIFO[chan_sel] count <= AE_THRESH
- err_overflow  out  NUM_CHANNELS  sticky: serve dropped because TX FIFO full
- err_underflow  out  NUM_CHANNELS  sticky: seize while RX FIFO empty

Behaviour:
- Reset: all FIFOs empty and all storage zeroed. send_val=0, recv_rdy=all 1s, to_master_val=0, to_master=0, counts=0, err_*=0, rx_almost_empty=1, tx_almost_full=(AF_THRESH==0).
- FIFO storage is a registered regfile with combinational read at the read pointer. Latency: an entry written at edge N is visible on deq outputs after edge N (one cycle). There is no bypass.
- enq_rdy = count < NUM_ENTRIES; deq_val = count != 0.
- Enqueue fires on enq_val & enq_rdy. Dequeue fires on deq_rdy & deq_val.
- Both fire in the same cycle: count unchanged, both pointers advance.
- A full FIFO does not accept an enqueue even when a dequeue fires that cycle.
- Pointers wrap from NUM_ENTRIES-1 to 0 (explicit compare, not bit overflow).
- Count saturates and never exceeds NUM_ENTRIES or underflows.
- TX enqueue for channel c = serve & !hard_msg & (chan_sel==c).
- TX dequeue for channel c = send_rdy[c].
- RX enqueue for channel c = recv_val[c].
- RX dequeue for channel c = seize & (chan_sel==c).
- Device-side handshakes on all channels proceed concurrently, independent of chan_sel.
- Overflow: serve & !hard_msg with TX FIFO[chan_sel] full. Data is dropped and err_overflow[chan_sel] is set at the next edge.
- Underflow: seize with RX FIFO[chan_sel] empty. No state change except err_underflow[chan_sel] set at the next edge.
- A set error flag holds until err_clear or reset. If err_clear and a new error on the same channel occur in the same cycle, the set wins.
- Flush: at the next edge, pointers and counts of both FIFOs of chan_sel go to 0.
  - Flush has priority over any same-cycle enqueue/dequeue on that channel; device-side transfers that cycle are discarded.
  - Flush does not touch the error flags or the other channels.
- chan_sel >= NUM_CHANNELS: master-side reads return 0, val returns 0, and serve/seize/flush/err_clear are ignored (no error flag set).
- Reset mid-operation: reset wins over everything; all state returns to reset values at the next edge.

Decomposition:
- Package spi_queue_pkg holds:
  - the localparam functions for CW and the count width;
  - a typedef for the per-FIFO status struct (count, full, empty).
- Sub-module spi_chan_fifo: parametrised FIFO (PACK_SIZE, NUM_ENTRIES) with val/rdy enq/deq, flush input and count output.
- The top instantiates 2*NUM_CHANNELS spi_chan_fifo in a generate loop, plus the master-side mux and the error flag registers.

Test Plan:
- Default parameters, ch0: serve 0xA, 0xB, 0xC, 0xD with send_rdy=0, then a fifth serve 0xE -> tx_count=4, tx_almost_full=1 from the 3rd enqueue, err_overflow=2'b01, send_val[0]=1, send_msg ch0=0xA.
- Then send_rdy[0]=1 for 4 cycles -> send_msg sequence 0xA, 0xB, 0xC, 0xD; 0xE never appears; send_val[0]=0 afterwards.
- NUM_ENTRIES=3: 10 alternating enqueue/dequeue cycles with the pointers wrapping -> data order preserved and count never exceeds 3.
- Simultaneous recv_val[1]=1 and seize on ch1 with count=2 -> count stays 2 and to_master advances to the next entry.
- seize on empty ch0, then err_clear on ch0 -> err_underflow[0] rises one cycle after the seize and falls one cycle after err_clear.
- Fill ch1 TX/RX with 2 entries each, assert flush with chan_sel=1 together with a serve -> both counts are 0 the next cycle; ch0 and the error flags are unchanged.
